// File: rtl/prm_edge_pkg.sv
// Shared types for the PRM obstacle-check frame collector.
package prm_edge_pkg;

    localparam int QW       = 15;
    localparam int NCHK_DEF = 64;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        OUT
    } state_e;

    typedef logic [QW-1:0] code_t;

endpackage

// File: rtl/prm_chk_valid_pipe.sv
// Valid/last shift register tracking query codes through the checker bank.
module prm_chk_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  logic push_valid_i,
    input  logic push_last_i,
    output logic out_valid_o,
    output logic out_last_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] last_q;
    logic [DEPTH-1:0] last_d;

    always_comb begin
        vld_d  = (vld_q << 1) | DEPTH'(push_valid_i);
        last_d = (last_q << 1) | DEPTH'(push_valid_i & push_last_i);
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/prm_edge_frame_collector.sv
// Streams voxel codes to the edge-checker bank and ORs the returned
// masks into one blocked-edge bitmap per frame.
module prm_edge_frame_collector
    import prm_edge_pkg::*;
#(
    parameter int NCHK    = NCHK_DEF,
    parameter int CHK_LAT = 1,
    parameter int CW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [QW-1:0]   s_code,
    input  logic            s_last,
    input  logic            abort,
    output logic [QW-1:0]   chk_code,
    input  logic [NCHK-1:0] chk_mask,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [NCHK-1:0] m_mask,
    output logic [CW-1:0]   m_count
);

    // Stage 0 lines up with chk_code; the rest cover the bank latency.
    localparam int PDEPTH = CHK_LAT + 1;

    state_e          state_q, state_d;
    code_t           code_q;
    logic [NCHK-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clr;
    logic            accept;
    logic            p_vld;
    logic            p_last;

    assign clr     = rst | abort;
    assign s_ready = (state_q == ACCUM) & ~rst;
    assign accept  = s_valid & s_ready & ~abort;

    prm_chk_valid_pipe #(
        .DEPTH(PDEPTH)
    ) u_pipe (
        .clk         (clk),
        .clr_i       (clr),
        .push_valid_i(accept),
        .push_last_i (s_last),
        .out_valid_o (p_vld),
        .out_last_o  (p_last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (p_vld) begin
            acc_d = acc_q | chk_mask;
        end
        if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            ACCUM: begin
                if (accept && s_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (p_vld && p_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort leaves the query bus alone; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
        end else if (accept) begin
            code_q <= s_code;
        end
    end

    assign chk_code = code_q;
    assign m_valid  = (state_q == OUT);
    assign m_mask   = acc_q;
    assign m_count  = cnt_q;

endmodule

// File: tb/tb_prm_edge_frame_collector.sv
// Scoreboard bench: instance 0 with CHK_LAT=1, instance 1 with CHK_LAT=3.
module tb_prm_edge_frame_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        s_valid[2];
    logic        s_ready[2];
    logic        s_last[2];
    logic        abort_[2];
    logic        m_valid[2];
    logic        m_ready[2];
    logic [14:0] s_code[2];
    logic [14:0] chk_code[2];
    logic [3:0]  chk_mask[2];
    logic [3:0]  m_mask[2];
    logic [3:0]  m_count[2];
    logic [3:0]  dl[2];

    prm_edge_frame_collector #(.NCHK(4), .CHK_LAT(1), .CW(4)) u0 (
        .clk(clk), .rst(rst[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_code(s_code[0]), .s_last(s_last[0]), .abort(abort_[0]),
        .chk_code(chk_code[0]), .chk_mask(chk_mask[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_mask(m_mask[0]), .m_count(m_count[0])
    );

    prm_edge_frame_collector #(.NCHK(4), .CHK_LAT(3), .CW(4)) u1 (
        .clk(clk), .rst(rst[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_code(s_code[1]), .s_last(s_last[1]), .abort(abort_[1]),
        .chk_code(chk_code[1]), .chk_mask(chk_mask[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_mask(m_mask[1]), .m_count(m_count[1])
    );

    // Checker bank models: mask = low nibble of the code, 1 or 3 cycles late.
    always @(posedge clk) begin
        chk_mask[0] <= chk_code[0][3:0];
        dl[0]       <= chk_code[1][3:0];
        dl[1]       <= dl[0];
        chk_mask[1] <= dl[1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    typedef struct {
        int mask;
        int cnt;
        int rise;
    } exp_t;

    exp_t q[2][$];
    int   hs[2];
    bit   prev_v[2];
    bit   post[2];
    int   hold[2];
    bit   force_rdy[2];
    int   fr_or[2];
    int   fr_n[2];
    int   last_acc[2];
    bit   done1 = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [14:0] rcode();
        int         r;
        logic [3:0] lo;
        logic [10:0] hi;
        r  = $urandom_range(9);
        hi = 11'($urandom);
        if (r < 2) lo = 4'h0;
        else if (r < 8) lo = 4'(1 << (r % 4));
        else lo = 4'hF;
        return {hi, lo};
    endfunction

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (hold[d] > 0) begin
                m_ready[d] = 1'b0;
                hold[d]--;
            end else begin
                m_ready[d] = force_rdy[d] ? 1'b1 : ($urandom_range(3) != 0);
            end
        end
    end

    // Monitor: compares every presented result against the queue head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (post[d]) begin
                chk_eq($sformatf("post_hs_m_valid%0d", d), int'(m_valid[d]), 0);
                chk_eq($sformatf("post_hs_s_ready%0d", d), int'(s_ready[d]), 1);
                post[d] = 0;
            end else if (m_valid[d] === 1'b1) begin
                chk_eq($sformatf("out_s_ready%0d", d), int'(s_ready[d]), 0);
                if (q[d].size() == 0) begin
                    chk_eq($sformatf("unexpected_m_valid%0d", d), int'(m_valid[d]), 0);
                end else begin
                    if (!prev_v[d])
                        chk_eq($sformatf("rise_cycle%0d", d), cyc, q[d][0].rise);
                    chk_eq($sformatf("m_mask%0d", d), int'(m_mask[d]), q[d][0].mask);
                    chk_eq($sformatf("m_count%0d", d), int'(m_count[d]), q[d][0].cnt);
                    if (m_ready[d]) begin
                        void'(q[d].pop_front());
                        hs[d]++;
                        post[d] = 1;
                    end
                end
            end
            prev_v[d] = (m_valid[d] === 1'b1);
        end
    end

    task automatic drive(input int d, input bit v, input logic [14:0] c,
                         input bit l, input bit ab);
        @(posedge clk);
        #1;
        s_valid[d] = v;
        s_code[d]  = c;
        s_last[d]  = l;
        abort_[d]  = ab;
        if (v) chk_eq($sformatf("s_ready_accum%0d", d), int'(s_ready[d]), 1);
        if (ab) begin
            fr_or[d] = 0;
            fr_n[d]  = 0;
        end else if (v) begin
            fr_or[d] = fr_or[d] | int'(c[3:0]);
            fr_n[d]++;
            if (l) last_acc[d] = cyc + 1;
        end
    endtask

    task automatic end_frame(input int d, input bit ab_drain);
        exp_t e;
        int   h0;
        int   t;
        @(posedge clk);
        #1;
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        abort_[d]  = ab_drain;
        chk_eq($sformatf("s_ready_drain%0d", d), int'(s_ready[d]), 0);
        e.mask = fr_or[d];
        e.cnt  = (fr_n[d] > 15) ? 15 : fr_n[d];
        e.rise = last_acc[d] + lat(d) + 1;
        fr_or[d] = 0;
        fr_n[d]  = 0;
        if (ab_drain) begin
            @(posedge clk);
            #1;
            abort_[d] = 1'b0;
            repeat (6) @(posedge clk);
        end else begin
            h0 = hs[d];
            q[d].push_back(e);
            t = 0;
            while (hs[d] == h0 && t < 300) begin
                @(posedge clk);
                t++;
            end
            if (hs[d] == h0) chk_eq($sformatf("hs_timeout%0d", d), hs[d], h0 + 1);
        end
    endtask

    task automatic do_reset(input int d);
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        abort_[d]  = 1'b0;
        s_code[d]  = '0;
        rst[d]     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq($sformatf("rst_s_ready%0d", d), int'(s_ready[d]), 0);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        @(negedge clk);
        chk_eq($sformatf("rst_m_valid%0d", d), int'(m_valid[d]), 0);
        chk_eq($sformatf("rst_m_mask%0d", d), int'(m_mask[d]), 0);
        chk_eq($sformatf("rst_m_count%0d", d), int'(m_count[d]), 0);
        chk_eq($sformatf("rst_chk_code%0d", d), int'(chk_code[d]), 0);
        chk_eq($sformatf("rst_s_ready_after%0d", d), int'(s_ready[d]), 1);
        fr_or[d] = 0;
        fr_n[d]  = 0;
    endtask

    task automatic rand_frames(input int d, input int n);
        int len;
        for (int f = 0; f < n; f++) begin
            force_rdy[d] = ($urandom_range(3) == 0);
            len = $urandom_range(20, 1);
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(3) == 0)
                    drive(d, 1'b0, rcode(), 1'b0, ($urandom_range(15) == 0));
                if (k < len - 1 && $urandom_range(19) == 0)
                    drive(d, 1'b1, rcode(), 1'b0, 1'b1);
                else
                    drive(d, 1'b1, rcode(), (k == len - 1), 1'b0);
            end
            end_frame(d, ($urandom_range(9) == 0));
        end
    endtask

    initial begin
        force_rdy[1] = 1'b1;
        hold[1] = 0;
        do_reset(1);
        drive(1, 1'b1, 15'h0001, 1'b0, 1'b0);
        drive(1, 1'b1, 15'h0004, 1'b0, 1'b0);
        drive(1, 1'b1, 15'h0008, 1'b1, 1'b0);
        end_frame(1, 1'b0);
        rand_frames(1, 12);
        done1 = 1;
    end

    initial begin
        force_rdy[0] = 1'b1;
        hold[0] = 0;
        do_reset(0);
        // Single frame, back-to-back
        drive(0, 1'b1, 15'h0001, 1'b0, 1'b0);
        drive(0, 1'b1, 15'h0004, 1'b0, 1'b0);
        drive(0, 1'b1, 15'h0008, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        // Backpressure
        force_rdy[0] = 1'b0;
        hold[0] = 8;
        drive(0, 1'b1, 15'h0002, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        // Next-frame isolation
        force_rdy[0] = 1'b1;
        drive(0, 1'b1, 15'h000F, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        drive(0, 1'b1, 15'h0001, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        // Abort pulse, then abort colliding with an accept
        drive(0, 1'b1, 15'h0008, 1'b0, 1'b0);
        drive(0, 1'b1, 15'h0004, 1'b0, 1'b0);
        drive(0, 1'b0, 15'h0000, 1'b0, 1'b1);
        drive(0, 1'b1, 15'h0001, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        drive(0, 1'b1, 15'h0002, 1'b0, 1'b0);
        drive(0, 1'b1, 15'h0004, 1'b0, 1'b1);
        drive(0, 1'b1, 15'h0001, 1'b1, 1'b0);
        end_frame(0, 1'b0);
        // Reset one cycle after the last accept
        drive(0, 1'b1, 15'h0003, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        s_last[0]  = 1'b0;
        rst[0]     = 1'b1;
        @(negedge clk);
        chk_eq("rst_drain_s_ready", int'(s_ready[0]), 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        fr_or[0] = 0;
        fr_n[0]  = 0;
        @(negedge clk);
        chk_eq("rst_drain_chk_code", int'(chk_code[0]), 0);
        chk_eq("rst_drain_s_ready_after", int'(s_ready[0]), 1);
        repeat (8) @(posedge clk);
        // Randomized frames, including saturation and drain aborts
        rand_frames(0, 40);
        for (int t = 0; t < 20000 && !done1; t++) @(posedge clk);
        if (!done1) chk_eq("inst1_done_timeout", int'(done1), 1);
        repeat (5) @(posedge clk);
        chk_eq("leftover_expect0", q[0].size(), 0);
        chk_eq("leftover_expect1", q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
